alu_multicycle: RTL
===================

# alu_multicycle

Parametrised, registered successor to the processor's combinational ALU. Executes all existing single-cycle operations with one cycle of latency. Adds iterative unsigned multiply, divide and remainder, plus overflow, divide-by-zero and invalid-opcode flags. Sits in the execute stage of the multi-cycle datapath; the control FSM issues a start pulse and stalls on busy until done.

## Interface
- WIDTH, 16, operand/result width (≥4)
- SHIFT_W, $clog2(WIDTH), shift-amount bits taken from input_B
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- input_Start  in  1  request; sampled only in IDLE
- input_ALUOp  in  4  operation code, sampled with input_Start
- input_A, input_B  in  WIDTH  operands, sampled with input_Start
- output_Busy  out  1  operation in progress
- output_Done  out  1  one-cycle pulse: result/flags updated
- output_ALU  out  WIDTH  registered result, held until next Done
- output_Zero, output_Negative, output_Carry, output_Overflow  out  1 each  registered flags
- output_DivZero, output_Invalid  out  1 each  registered exception flags

## Operation
- FSM states: IDLE, ITER. Reset → IDLE; all outputs 0.
- Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sla (= sll), 1000 sra, 1100 pass B, 1101 pass A, 1001 mul (low WIDTH bits), 1010 divu quotient, 1011 remu remainder. Codes 1110/1111 are invalid.
- Shift amount: input_B[SHIFT_W-1:0]. sra fills with A[WIDTH-1] (true sign fill).
- Single-cycle ops (everything except 1001-1011): in IDLE with Start, the result is computed from live inputs and registered on that edge; Done pulses next cycle; state stays IDLE.
- Mul/div: Start latches A, B and the opcode, loads the iteration counter with WIDTH-1, and moves to ITER; Busy goes high.
  - mul: shift-add, one bit per cycle.
  - div/rem: restoring division, one quotient bit per cycle.
  - Counter 0 → result registered, Done pulses, return to IDLE.
- Carry: add = carry out of bit WIDTH-1; sub = borrow (A<B unsigned). 0 for all other ops.
- Overflow: signed overflow for add/sub only; 0 otherwise.
- Zero/Negative: derived from the registered result for every op.
- Divide by zero (B=0, 1010/1011): no iteration. Latency is 1 like single-cycle ops; quotient = all ones, remainder = A; DivZero=1.
- Invalid opcode: result 0, Invalid=1, Zero=1, latency 1.
- DivZero and Invalid are cleared on every Done that does not set them.
- Start while Busy: ignored, no effect on the operation in flight or on its operands.

## Timing
- Start accepted at edge t0.
  - Single-cycle op: output_ALU/flags valid and Done=1 during the cycle after t0.
  - Mul/div: Busy=1 from t0 until edge t0+WIDTH; Done=1 and result valid after edge t0+WIDTH (WIDTH-cycle latency).
- Done and Busy are never both high.
- Back-to-back: Start sampled in the Done cycle is accepted (state is IDLE).
- Reset has priority over all else, including mid-ITER: return to IDLE, zero outputs, no Done.
- Outputs change only on a Done edge or on Reset.

## Structure
- Package alu_pkg: opcode localparams, the FSM state enum, the DivZero quotient constant (all ones).
- Sub-module alu_iter_muldiv: owns the shift-add / restoring-divide datapath and the iteration counter. Interface: load, op select, operands, result, last.
- Single-cycle result/flag logic is a combinational function in the top module.

## Test plan
- WIDTH=16, add 0xFFFF+0x0001 → Done one cycle after Start; ALU=0x0000, Zero=1, Carry=1, Overflow=0.
- sub 0x8000−0x0001 → ALU=0x7FFF, Overflow=1, Carry=0. sra 0x8000 by B=4 → ALU=0xF800, Negative=1.
- mul 0x0123×0x0045 → Busy 16 cycles, Done at t0+16 with ALU=0x4E6F. A second Start mid-operation is ignored.
- divu 1000/7 → ALU=142; remu 1000/7 → ALU=6. divu 5/0 → one-cycle latency, ALU=0xFFFF, DivZero=1.
- Opcode 1110 → ALU=0, Invalid=1, Zero=1. The next valid op clears Invalid.
- Reset asserted mid-mul at cycle 8 → IDLE next edge, all outputs 0, no Done. A Start the following cycle completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and constants
// for the registered multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SLA   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_PASSB = 4'b1100;
  localparam logic [3:0] OP_PASSA = 4'b1101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_e;

  // Quotient returned on divide by zero;
  // sliced down to the operand width.
  localparam int unsigned MAX_W = 64;
  localparam logic [MAX_W-1:0] DIVZ_QUO = '1;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply / divide:
// one product or quotient bit per step.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             last_o
);

  localparam int CNT_W = $clog2(WIDTH);

  // acc: product accumulator / partial remainder
  // opa: shifted multiplicand / dividend->quotient
  // opb: shifted multiplier / divisor
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic               qbit;

  // Load operands or advance one shift-add / restoring step
  always_comb begin
    op_d  = op_q;
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    shl   = '0;
    diff  = '0;
    qbit  = 1'b0;
    if (load_i) begin
      op_d  = op_i;
      acc_d = '0;
      opa_d = a_i;
      opb_d = b_i;
      cnt_d = CNT_W'(WIDTH - 1);
    end else if (step_i) begin
      cnt_d = cnt_q - 1'b1;
      if (op_q == MD_MUL) begin
        if (opb_q[0]) begin
          acc_d = acc_q + opa_q;
        end
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else begin
        shl  = {acc_q, opa_q[WIDTH-1]};
        diff = shl - {1'b0, opb_q};
        qbit = ~diff[WIDTH];
        if (qbit) begin
          acc_d = diff[WIDTH-1:0];
        end else begin
          acc_d = shl[WIDTH-1:0];
        end
        opa_d = {opa_q[WIDTH-2:0], qbit};
      end
    end
  end

  // Result reflects the step being taken this cycle,
  // so the top can register it on the final edge.
  assign result_o = (op_q == MD_DIV) ? opa_d : acc_d;
  assign last_o   = (cnt_q == '0);

  // Datapath and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q  <= MD_MUL;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle ops with one cycle
// of latency plus iterative mul / divu / remu.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             input_Start,
  input  logic [3:0]       input_ALUOp,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  output logic             output_Busy,
  output logic             output_Done,
  output logic [WIDTH-1:0] output_ALU,
  output logic             output_Zero,
  output logic             output_Negative,
  output logic             output_Carry,
  output logic             output_Overflow,
  output logic             output_DivZero,
  output logic             output_Invalid
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             dz;
    logic             inv;
  } sc_t;

  // Everything that completes without iterating.
  // divu/remu only reach here with a zero divisor.
  function automatic sc_t single_op(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    sc_t                r;
    logic [WIDTH:0]     wide;
    logic [SHIFT_W-1:0] sh;
    r    = '0;
    wide = '0;
    sh   = b[SHIFT_W-1:0];
    unique case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
        r.v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
        r.v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   r.res = a & b;
      OP_OR:    r.res = a | b;
      OP_XOR:   r.res = a ^ b;
      OP_SLL,
      OP_SLA:   r.res = a << sh;
      OP_SRL:   r.res = a >> sh;
      OP_SRA:   r.res = $unsigned($signed(a) >>> sh);
      OP_PASSB: r.res = b;
      OP_PASSA: r.res = a;
      OP_DIVU: begin
        r.res = DIVZ_QUO[WIDTH-1:0];
        r.dz  = 1'b1;
      end
      OP_REMU: begin
        r.res = a;
        r.dz  = 1'b1;
      end
      default:  r.inv = 1'b1;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             inv_q, inv_d;

  logic             is_div;
  logic             starts_iter;
  logic             md_load;
  logic             md_step;
  md_op_e           md_op;
  logic [WIDTH-1:0] md_result;
  logic             md_last;
  sc_t              sc;

  assign is_div      = (input_ALUOp == OP_DIVU) ||
                       (input_ALUOp == OP_REMU);
  assign starts_iter = (input_ALUOp == OP_MUL) ||
                       (is_div && (|input_B));
  assign md_op       = (input_ALUOp == OP_MUL)  ? MD_MUL :
                       (input_ALUOp == OP_DIVU) ? MD_DIV :
                                                  MD_REM;
  assign md_step     = (state_q == ST_ITER);

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .load_i  (md_load),
    .step_i  (md_step),
    .op_i    (md_op),
    .a_i     (input_A),
    .b_i     (input_B),
    .result_o(md_result),
    .last_o  (md_last)
  );

  // Accept requests, finish iterations, update result/flags
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    alu_d   = alu_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    inv_d   = inv_q;
    md_load = 1'b0;
    sc      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (input_Start) begin
          if (starts_iter) begin
            md_load = 1'b1;
            state_d = ST_ITER;
          end else begin
            sc      = single_op(input_ALUOp,
                                input_A, input_B);
            alu_d   = sc.res;
            carry_d = sc.c;
            ovf_d   = sc.v;
            dz_d    = sc.dz;
            inv_d   = sc.inv;
            done_d  = 1'b1;
          end
        end
      end
      ST_ITER: begin
        if (md_last) begin
          alu_d   = md_result;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          inv_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done_d) begin
      zero_d = (alu_d == '0);
      neg_d  = alu_d[WIDTH-1];
    end
  end

  // State and output registers; reset wins over everything
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      inv_q   <= inv_d;
    end
  end

  assign output_Busy     = md_step;
  assign output_Done     = done_q;
  assign output_ALU      = alu_q;
  assign output_Zero     = zero_q;
  assign output_Negative = neg_q;
  assign output_Carry    = carry_q;
  assign output_Overflow = ovf_q;
  assign output_DivZero  = dz_q;
  assign output_Invalid  = inv_q;

endmodule
